// File: rtl/vgachargen_mem_ctrl.sv
// Port A access controller for the character/colour map BRAMs: host requester plus screen-fill engine.
// Optional fill engine enabled by defining VGACHARGEN_MEM_CTRL_FILL_EN.
module vgachargen_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned CH_DATA_WIDTH  = 8,
  parameter int unsigned COL_DATA_WIDTH = 8,
  parameter int unsigned CELL_COUNT     = 2400
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      host_req_i,
  input  logic                      host_we_i,
  input  logic [1:0]                host_wmask_i,
  input  logic [ADDR_WIDTH-1:0]     host_addr_i,
  input  logic [CH_DATA_WIDTH-1:0]  host_ch_wdata_i,
  input  logic [COL_DATA_WIDTH-1:0] host_col_wdata_i,
  output logic                      host_gnt_o,
  output logic                      host_rvalid_o,
  output logic [CH_DATA_WIDTH-1:0]  host_ch_rdata_o,
  output logic [COL_DATA_WIDTH-1:0] host_col_rdata_o,
  input  logic                      fill_start_i,
  input  logic [CH_DATA_WIDTH-1:0]  fill_ch_i,
  input  logic [COL_DATA_WIDTH-1:0] fill_col_i,
  output logic                      fill_busy_o,
  output logic                      fill_done_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic                      ch_map_wen_o,
  output logic                      col_map_wen_o,
  output logic [CH_DATA_WIDTH-1:0]  ch_map_wdata_o,
  output logic [COL_DATA_WIDTH-1:0] col_map_wdata_o,
  input  logic [CH_DATA_WIDTH-1:0]  ch_map_rdata_i,
  input  logic [COL_DATA_WIDTH-1:0] col_map_rdata_i
);

  logic host_gnt;

`ifdef VGACHARGEN_MEM_CTRL_FILL_EN
  typedef enum logic {IDLE, FILL} state_e;

  state_e                    state;
  logic [ADDR_WIDTH-1:0]     cnt;
  logic                      last_fill;
  logic [CH_DATA_WIDTH-1:0]  fill_ch_q;
  logic [COL_DATA_WIDTH-1:0] fill_col_q;
  logic                      fill_we;
  logic                      last_cell;

  // Round-robin: in FILL the host only wins right after a fill write.
  always_comb begin
    fill_we   = (state == FILL) && !(host_req_i && last_fill);
    host_gnt  = host_req_i && !arst_i && ((state == IDLE) || last_fill);
    last_cell = (cnt == ADDR_WIDTH'(CELL_COUNT - 1));
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      last_fill   <= 1'b0;
      fill_ch_q   <= '0;
      fill_col_q  <= '0;
      fill_done_o <= 1'b0;
    end else begin
      fill_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_start_i) begin
            fill_ch_q  <= fill_ch_i;
            fill_col_q <= fill_col_i;
            cnt        <= '0;
            last_fill  <= 1'b0;
            state      <= FILL;
          end
        end
        FILL: begin
          last_fill <= fill_we;
          if (fill_we) begin
            // Counter parks on the last cell rather than stepping past it.
            if (last_cell) begin
              state       <= IDLE;
              fill_done_o <= 1'b1;
            end else begin
              cnt <= cnt + ADDR_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fill_busy_o = (state == FILL);
`else
  logic unused_fill;

  assign unused_fill = ^{fill_start_i, fill_ch_i, fill_col_i};
  assign host_gnt    = host_req_i & ~arst_i;
  assign fill_busy_o = 1'b0;
  assign fill_done_o = 1'b0;
`endif

  // Port A mux: host by default, fill engine overrides when it owns the cycle.
  always_comb begin
    mem_addr_o      = host_addr_i;
    ch_map_wen_o    = host_gnt & host_we_i & host_wmask_i[0];
    col_map_wen_o   = host_gnt & host_we_i & host_wmask_i[1];
    ch_map_wdata_o  = host_ch_wdata_i;
    col_map_wdata_o = host_col_wdata_i;
`ifdef VGACHARGEN_MEM_CTRL_FILL_EN
    if (fill_we) begin
      mem_addr_o      = cnt;
      ch_map_wen_o    = 1'b1;
      col_map_wen_o   = 1'b1;
      ch_map_wdata_o  = fill_ch_q;
      col_map_wdata_o = fill_col_q;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) host_rvalid_o <= 1'b0;
    else        host_rvalid_o <= host_gnt & ~host_we_i;
  end

  assign host_gnt_o       = host_gnt;
  assign host_ch_rdata_o  = ch_map_rdata_i;
  assign host_col_rdata_o = col_map_rdata_i;

endmodule

// File: doc/vgachargen_mem_ctrl.md
# vgachargen_mem_ctrl

Access controller for the host-side port (port A) of the character map and colour map BRAMs of the VGA character generator. It shares that single port between a bus-facing host requester and a built-in screen-fill engine, using round-robin arbitration while a fill is running. It drives one address shared by both maps and returns read data one cycle after a granted read. The display-side port B is not touched.

## Interface
- `ADDR_WIDTH`, 12: cell address width, shared by ch_map and col_map.
- `CH_DATA_WIDTH`, 8: ch_map word width (character index plus RO/RW table select bit).
- `COL_DATA_WIDTH`, 8: col_map word width (fg nibble in the upper half, bg nibble in the lower half).
- `CELL_COUNT`, 2400: number of screen cells; fill covers addresses 0..CELL_COUNT-1.

Ports:
- `clk_i` in 1: clock.
- `arst_i` in 1: reset, asynchronous, active-high.
- `host_req_i` in 1: host access request; held until granted.
- `host_we_i` in 1: 1 = write, 0 = read.
- `host_wmask_i` in 2: write enables; bit0 = ch_map, bit1 = col_map.
- `host_addr_i` in ADDR_WIDTH: cell address.
- `host_ch_wdata_i` in CH_DATA_WIDTH: write data for ch_map.
- `host_col_wdata_i` in COL_DATA_WIDTH: write data for col_map.
- `host_gnt_o` out 1: access performed this cycle.
- `host_rvalid_o` out 1: read data valid, one cycle after a granted read.
- `host_ch_rdata_o` out CH_DATA_WIDTH: ch_map read data.
- `host_col_rdata_o` out COL_DATA_WIDTH: col_map read data.
- `fill_start_i` in 1: start-fill pulse.
- `fill_ch_i` in CH_DATA_WIDTH: fill character, sampled at start.
- `fill_col_i` in COL_DATA_WIDTH: fill colour, sampled at start.
- `fill_busy_o` out 1: fill in progress.
- `fill_done_o` out 1: one-cycle completion pulse.
- `mem_addr_o` out ADDR_WIDTH: port A address to both maps.
- `ch_map_wen_o`, `col_map_wen_o` out 1 each: port A write enables.
- `ch_map_wdata_o` out CH_DATA_WIDTH, `col_map_wdata_o` out COL_DATA_WIDTH: port A write data.
- `ch_map_rdata_i` in CH_DATA_WIDTH, `col_map_rdata_i` in COL_DATA_WIDTH: port A read data, 1-cycle BRAM latency.

## Operation
- FSM has two states, IDLE and FILL. Reset state is IDLE.
- IDLE:
  - `host_gnt_o = host_req_i`.
  - A granted host cycle drives `mem_addr_o = host_addr_i`.
  - Write enables are `host_we_i & host_wmask_i[n]`; a read asserts no wen.
- IDLE and `fill_start_i`:
  - Latch `fill_ch_i` and `fill_col_i`, clear the cell counter, and go to FILL next cycle.
  - A host request in the same cycle is still granted.
- FILL arbitration, using a 1-bit `last_fill` flag:
  - Host is granted iff `host_req_i && last_fill`.
  - Otherwise the fill engine owns the cycle: `mem_addr_o = cnt`, both wens = 1, write data = the latched values, `cnt++`.
  - `last_fill` is set when the fill wrote this cycle and cleared otherwise. Entering FILL sets it to 0, so the first FILL cycle goes to the fill engine.
- FILL completion: the cycle that writes `cnt == CELL_COUNT-1` returns the FSM to IDLE; `fill_done_o` pulses on the next cycle.
- `fill_start_i` while in FILL is ignored; the running fill is not restarted.
- Counter arithmetic is in ADDR_WIDTH bits and never exceeds CELL_COUNT-1, so it does not wrap.
- Reads:
  - `host_rvalid_o` is a register holding `host_gnt_o & ~host_we_i`.
  - `host_*_rdata_o` pass `*_rdata_i` through combinationally.
  - rdata is don't-care when rvalid is 0.
- Idle bus: with no grant and no fill write, all wens = 0 and `mem_addr_o` holds `host_addr_i`.
- Reset mid-fill:
  - The fill is abandoned and the FSM returns to IDLE.
  - No done pulse is issued; cells already written stay written.
  - A pending rvalid is dropped.

## Timing
- Reset values: `fill_busy_o` 0, `fill_done_o` 0, `host_rvalid_o` 0, all wens 0, `host_gnt_o` 0, counter 0, `last_fill` 0.
- Grant is combinational, same cycle as the request. Write latency is 0: the BRAM captures the write on the grant edge.
- Read latency is 1 cycle, from the grant edge to `host_rvalid_o`.
- `fill_busy_o` is high from the cycle after start through the last fill write.
- Fill duration: CELL_COUNT cycles with no host traffic. Under continuous host requests it is 2*CELL_COUNT-1 cycles.
- Host wait in FILL is at most 1 cycle.
- Back-to-back host accesses are allowed in IDLE, one per cycle.

## Configuration
- `VGACHARGEN_MEM_CTRL_FILL_EN` defined: the fill engine, FSM and arbitration are built as described.
- Not defined:
  - No FSM or counter is built.
  - `fill_start_i`, `fill_ch_i` and `fill_col_i` are ignored.
  - `fill_busy_o` and `fill_done_o` are tied to 0.
  - `host_gnt_o = host_req_i` always.

## Test plan
- Host write then read: write addr 0x005, ch 0x41, col 0xF0 (mask 2'b11), then read 0x005 → gnt same cycle as each request; rvalid 1 cycle after the read grant; rdata 0x41 / 0xF0.
- Masked write: mask 2'b01, ch 0x22 to addr 0x010 → only `ch_map_wen_o` pulses; col_map is unchanged on readback.
- Fill, no host traffic: start with ch 0x20, col 0x0F → busy for exactly 2400 cycles; done pulses on cycle 2401; sampled cells 0, 1234 and 2399 read 0x20 / 0x0F.
- Fill with continuous host reads of addr 0x000:
  - Grants alternate with fill writes.
  - Every host read completes within 2 cycles.
  - Fill finishes in 4799 cycles.
- Simultaneous start and host write in IDLE → host is granted that cycle; the fill starts next cycle; `fill_start_i` pulsed again during FILL has no effect and produces a single done pulse.
- Assert `arst_i` at fill cell 1000 → busy, done, rvalid and wens go to 0 immediately; after release, a host access in IDLE is granted at once.
